// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter.
//   state_e : arbiter FSM states
//   OWN_I / OWN_D : owner encoding used for grant bookkeeping
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        ACK   = 2'd3
    } state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb2_pick.sv
// Combinational two-requester picker.
//   req_i, req_d  : pending requests from I-cache and D-cache
//   last_grant    : owner of the previous grant (OWN_I / OWN_D)
//   grant_d       : 1 = D wins, 0 = I wins (meaningful when grant_valid)
//   grant_valid   : at least one request pending
module arb2_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned D_PRIORITY = 1
) (
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_d,
    output logic grant_valid
);

    localparam logic PRIO_D = (D_PRIORITY != 0);

    // On a tie, D wins under fixed priority; otherwise the side not served last.
    always_comb begin
        grant_valid = req_i | req_d;
        grant_d     = req_d & (~req_i | PRIO_D | (last_grant == OWN_I));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between I-cache and D-cache block transfers.
//   clk, rst          : clock, synchronous active-high reset
//   i_req/i_addr      : I-cache refill request (held until i_ack)
//   i_rdata/i_ack     : returned line and one-cycle completion pulse
//   d_req/d_wen/d_addr/d_wdata : D-cache refill (wen=0) or write-back (wen=1)
//   d_rdata/d_ack     : returned line and one-cycle completion pulse
//   mem_*             : registered memory strobes, address, write data; mem_ready/mem_rdata back
//   stall             : combinational pipeline freeze while any request is unacknowledged
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned D_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;

    logic grant_d;
    logic grant_valid;

    arb2_pick #(
        .D_PRIORITY (D_PRIORITY)
    ) u_pick (
        .req_i       (i_req),
        .req_d       (d_req),
        .last_grant  (last_grant_q),
        .grant_d     (grant_d),
        .grant_valid (grant_valid)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_d) begin
                        last_grant_d = OWN_D;
                        mem_addr_d   = d_addr;
                        mem_wdata_d  = d_wdata;
                        mem_write_d  = d_wen;
                        mem_read_d   = ~d_wen;
                        state_d      = GNT_D;
                    end else begin
                        last_grant_d = OWN_I;
                        mem_addr_d   = i_addr;
                        mem_read_d   = 1'b1;
                        state_d      = GNT_I;
                    end
                end
            end
            GNT_I, GNT_D: begin
                // Strobes stay stable until memory completes; read data is
                // captured only for reads so a write-back leaves d_rdata alone.
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (state_q == GNT_D) begin
                        if (mem_read_q) begin
                            d_rdata_d = mem_rdata;
                        end
                        d_ack_d = 1'b1;
                    end else begin
                        i_rdata_d = mem_rdata;
                        i_ack_d   = 1'b1;
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                // Requests are not sampled here, forcing one IDLE turnaround.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;

    // Freeze drops in the ack cycle unless the other side is still waiting.
    assign stall = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory
// transactions and acks into queues, monitors pop and compare on negedge.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 128;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        int            cycles;
    } mem_exp_t;

    typedef struct {
        logic          own;
        logic [DW-1:0] rdata;
    } ack_exp_t;

    logic          clk;
    logic          rst;
    logic          i_req, d_req, d_wen, mem_ready;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic          i_ack, d_ack, mem_read, mem_write, stall;

    logic          rr_i_req, rr_d_req, rr_i_ack, rr_d_ack;
    logic          rr_mem_read, rr_mem_write, rr_stall;
    logic [AW-1:0] rr_mem_addr;
    logic [DW-1:0] rr_i_rdata, rr_d_rdata, rr_mem_wdata;
    logic          rr_mem_ready;
    logic [DW-1:0] rr_mem_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    mem_exp_t mem_q[$];
    ack_exp_t ack_q[$];
    logic     rr_q[$];
    logic [DW-1:0] exp_i_rdata = '0;
    logic [DW-1:0] exp_d_rdata = '0;

    int            mem_lat = 1;
    int            strobe_cnt = 0;
    int            stray_req = 0;
    int            stray_done = 0;
    logic [DW-1:0] rd_pattern = '0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_PRIORITY(1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall)
    );

    // Round-robin instance with a zero-wait memory that echoes the address.
    assign rr_mem_ready = rr_mem_read | rr_mem_write;
    assign rr_mem_rdata = DW'(rr_mem_addr);

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_PRIORITY(0)) dut_rr (
        .clk(clk), .rst(rst),
        .i_req(rr_i_req), .i_addr(AW'(32'h10)), .i_rdata(rr_i_rdata), .i_ack(rr_i_ack),
        .d_req(rr_d_req), .d_wen(1'b0), .d_addr(AW'(32'h20)), .d_wdata('0),
        .d_rdata(rr_d_rdata), .d_ack(rr_d_ack),
        .mem_read(rr_mem_read), .mem_write(rr_mem_write), .mem_addr(rr_mem_addr),
        .mem_wdata(rr_mem_wdata), .mem_rdata(rr_mem_rdata), .mem_ready(rr_mem_ready),
        .stall(rr_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_mis++;
        $display("FAIL %s", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_mem(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd, input int cyc);
        mem_exp_t e;
        e.addr = a; e.wr = wr; e.wdata = wd; e.cycles = cyc;
        mem_q.push_back(e);
    endtask

    task automatic push_ack(input logic own, input logic is_read, input logic [DW-1:0] rd);
        ack_exp_t e;
        if (is_read) begin
            if (own) exp_d_rdata = rd;
            else     exp_i_rdata = rd;
        end
        e.own   = own;
        e.rdata = own ? exp_d_rdata : exp_i_rdata;
        ack_q.push_back(e);
    endtask

    task automatic wait_ack(input logic own, input bit chk_stall);
        bit got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            step();
            if (own ? d_ack : i_ack) got = 1'b1;
            else if (chk_stall) check("stall_hold", DW'(stall), DW'(1));
        end
        if (!got) fail(own ? "d_ack_timeout" : "i_ack_timeout");
    endtask

    // Memory model: answers after mem_lat strobe cycles (0 = never), plus stray pulses in idle.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            mem_rdata = ~rd_pattern;
            if (mem_read | mem_write) begin
                strobe_cnt++;
                if (mem_lat != 0 && strobe_cnt == mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd_pattern;
                end
            end else begin
                strobe_cnt = 0;
                if (stray_req != stray_done) begin
                    stray_done++;
                    mem_ready = 1'b1;
                    mem_rdata = rd_pattern;
                end
            end
        end
    end

    // Monitor for the priority instance.
    initial begin
        mem_exp_t cur;
        ack_exp_t ea;
        logic     prev_strobe = 1'b0;
        logic     strobe;
        int       cnt = 0;
        cur.addr = '0; cur.wr = 1'b0; cur.wdata = '0; cur.cycles = 0;
        forever begin
            @(negedge clk);
            strobe = (mem_read === 1'b1) || (mem_write === 1'b1);
            if (strobe) begin
                check("strobe_excl", DW'(mem_read & mem_write), DW'(0));
                if (!prev_strobe) begin
                    cnt = 1;
                    if (mem_q.size() == 0) fail("unexpected_strobe");
                    else cur = mem_q.pop_front();
                end else begin
                    cnt++;
                end
                check("mem_addr", DW'(mem_addr), DW'(cur.addr));
                check("mem_write", DW'(mem_write), DW'(cur.wr));
                if (cur.wr) check("mem_wdata", mem_wdata, cur.wdata);
            end else if (prev_strobe) begin
                check("strobe_cycles", DW'(cnt), DW'(cur.cycles));
            end
            prev_strobe = strobe;

            if (i_ack === 1'b1 || d_ack === 1'b1) begin
                check("ack_excl", DW'(i_ack & d_ack), DW'(0));
                if (ack_q.size() == 0) begin
                    fail("unexpected_ack");
                end else begin
                    ea = ack_q.pop_front();
                    check("ack_owner", DW'(d_ack), DW'(ea.own));
                    check(ea.own ? "d_rdata" : "i_rdata", ea.own ? d_rdata : i_rdata, ea.rdata);
                end
            end

            if (i_req || d_req)
                check("stall_eq", DW'(stall), DW'((i_req & ~i_ack) | (d_req & ~d_ack)));
        end
    end

    // Monitor for the round-robin instance.
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            if (rr_i_ack === 1'b1 || rr_d_ack === 1'b1) begin
                if (rr_q.size() == 0) begin
                    fail("rr_unexpected_ack");
                end else begin
                    e = rr_q.pop_front();
                    check("rr_grant_order", DW'(rr_d_ack), DW'(e));
                    check("rr_rdata", e ? rr_d_rdata : rr_i_rdata, e ? DW'(32'h20) : DW'(32'h10));
                end
            end
        end
    end

    task automatic rr_pair();
        rr_q.push_back(1'b1);
        rr_q.push_back(1'b0);
        rr_i_req = 1'b1;
        rr_d_req = 1'b1;
        for (int c = 0; c < 30 && (rr_i_req || rr_d_req); c++) begin
            step();
            if (rr_d_ack) rr_d_req = 1'b0;
            if (rr_i_ack) rr_i_req = 1'b0;
        end
        if (rr_i_req || rr_d_req) fail("rr_timeout");
        rr_i_req = 1'b0;
        rr_d_req = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        rr_i_req = 1'b0; rr_d_req = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state.
        check("rst_mem_read", DW'(mem_read), DW'(0));
        check("rst_mem_write", DW'(mem_write), DW'(0));
        check("rst_acks", DW'({i_ack, d_ack}), DW'(0));
        check("rst_mem_addr", DW'(mem_addr), DW'(0));
        check("rst_rdata", i_rdata | d_rdata | mem_wdata, '0);
        check("rst_stall", DW'(stall), DW'(0));

        // Round-robin from reset: D, I, D, I.
        rr_pair();
        rr_pair();

        // Lone I refill, ready in the second strobe cycle.
        rd_pattern = 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;
        mem_lat = 2;
        push_mem(AW'(32'h100), 1'b0, '0, 2);
        push_ack(1'b0, 1'b1, rd_pattern);
        i_addr = AW'(32'h100);
        i_req = 1'b1;
        wait_ack(1'b0, 1'b1);
        check("t1_stall_in_ack", DW'(stall), DW'(0));
        check("t1_i_rdata", i_rdata, 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C);
        i_req = 1'b0;
        step();

        // D refill then D write-back; write must leave d_rdata alone.
        rd_pattern = 128'hA5A5A5A5_11112222_33334444_55556666;
        mem_lat = 1;
        push_mem(AW'(32'h77), 1'b0, '0, 1);
        push_ack(1'b1, 1'b1, rd_pattern);
        d_addr = AW'(32'h77); d_wen = 1'b0; d_req = 1'b1;
        wait_ack(1'b1, 1'b1);
        d_req = 1'b0;
        step();
        rd_pattern = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
        push_mem(AW'(32'h2A), 1'b1, DW'(32'h1234), 1);
        push_ack(1'b1, 1'b0, '0);
        d_addr = AW'(32'h2A); d_wen = 1'b1; d_wdata = DW'(32'h1234); d_req = 1'b1;
        wait_ack(1'b1, 1'b1);
        check("t2_d_rdata_kept", d_rdata, 128'hA5A5A5A5_11112222_33334444_55556666);
        d_req = 1'b0; d_wen = 1'b0;
        step();

        // Simultaneous requests, fixed D priority: D, turnaround, I.
        rd_pattern = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;
        mem_lat = 1;
        push_mem(AW'(32'h40), 1'b0, '0, 1);
        push_ack(1'b1, 1'b1, rd_pattern);
        push_mem(AW'(32'h180), 1'b0, '0, 1);
        push_ack(1'b0, 1'b1, rd_pattern);
        d_addr = AW'(32'h40); i_addr = AW'(32'h180);
        d_req = 1'b1; i_req = 1'b1;
        wait_ack(1'b1, 1'b1);
        check("t3_stall_d_ack", DW'(stall), DW'(1));
        d_req = 1'b0;
        step();
        check("t3_turnaround_idle", DW'({mem_read, mem_write}), DW'(0));
        check("t3_stall_idle", DW'(stall), DW'(1));
        step();
        check("t3_i_strobe", DW'(mem_read), DW'(1));
        wait_ack(1'b0, 1'b1);
        i_req = 1'b0;
        step();

        // Reset while waiting in GNT_D: no ack, everything cleared.
        mem_lat = 0;
        push_mem(AW'(32'h55), 1'b0, '0, 3);
        d_addr = AW'(32'h55); d_req = 1'b1;
        step(); step(); step();
        rst = 1'b1; d_req = 1'b0;
        step();
        rst = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        check("t5_rst_strobes", DW'({mem_read, mem_write, i_ack, d_ack}), DW'(0));
        check("t5_rst_addr", DW'(mem_addr), DW'(0));
        check("t5_rst_data", i_rdata | d_rdata | mem_wdata, '0);
        step(); step();
        rd_pattern = 128'h13579BDF_2468ACE0_13579BDF_2468ACE0;
        mem_lat = 3;
        push_mem(AW'(32'h300), 1'b0, '0, 3);
        push_ack(1'b0, 1'b1, rd_pattern);
        i_addr = AW'(32'h300); i_req = 1'b1;
        wait_ack(1'b0, 1'b1);
        i_req = 1'b0;
        step();

        // Requester drops in the first grant cycle; then a stray ready in IDLE.
        rd_pattern = 128'hCAFEBABE_CAFEBABE_00000000_12345678;
        mem_lat = 2;
        push_mem(AW'(32'h66), 1'b0, '0, 2);
        push_ack(1'b1, 1'b1, rd_pattern);
        d_addr = AW'(32'h66); d_wen = 1'b0; d_req = 1'b1;
        step();
        d_req = 1'b0;
        wait_ack(1'b1, 1'b0);
        step(); step();
        stray_req++;
        for (int c = 0; c < 4; c++) begin
            step();
            check("t6_no_ack_after_stray", DW'({i_ack, d_ack, mem_read, mem_write}), DW'(0));
        end

        check("end_mem_q_empty", DW'(mem_q.size()), DW'(0));
        check("end_ack_q_empty", DW'(ack_q.size()), DW'(0));
        check("end_rr_q_empty", DW'(rr_q.size()), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external main-memory port between the I-cache and D-cache miss/refill paths.
- Serialises their block transfers with a small FSM and generates the pipeline `stall` that freezes the fetch and MEM/WB pipeline registers while a miss is outstanding.
- Sits between the two cache controllers and the memory model.
- Owns arbitration policy, request latching, and the one-cycle completion handshake.

Parameters:
- ADDR_W, 30, block/word address width from caches
- DATA_W, 128, cache line width transferred per transaction
- D_PRIORITY, 1, 1 = D-cache always wins a tie; 0 = round-robin on tie

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  I-cache read request, held until i_ack
- i_addr  in  ADDR_W  I-cache miss address
- i_rdata  out  DATA_W  line returned to I-cache
- i_ack  out  1  one-cycle completion pulse to I-cache
- d_req  in  1  D-cache request, held until d_ack
- d_wen  in  1  1 = write-back, 0 = refill read
- d_addr  in  ADDR_W  D-cache address
- d_wdata  in  DATA_W  write-back line
- d_rdata  out  DATA_W  line returned to D-cache
- d_ack  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, one cycle
- stall  out  1  pipeline freeze

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All flops update on posedge clk. When rst=1 at an edge the next state is:
  - FSM in IDLE.
  - mem_read, mem_write, i_ack, d_ack all 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata all 0.
  - last_grant = I.
- FSM states: IDLE, GNT_I, GNT_D, ACK.
- IDLE, choosing the grant:
  - Only i_req=1 → GNT_I.
  - Only d_req=1 → GNT_D.
  - Both set with D_PRIORITY=1 → GNT_D.
  - Both set with D_PRIORITY=0 → grant the requester not equal to last_grant.
- IDLE, on the granting edge:
  - Latch the winner's address into mem_addr.
  - For D, also latch d_wdata and d_wen.
  - Update last_grant.
- GNT_x:
  - mem_read=1 (or mem_write=1 for a D write) is registered and held stable, with mem_addr/mem_wdata unchanged, until mem_ready=1.
  - On the mem_ready edge, a read captures mem_rdata into x_rdata. Strobes clear on the same edge. → ACK.
- ACK:
  - Assert x_ack=1 for exactly this cycle, then → IDLE.
  - Requests are not sampled in ACK, so there is a mandatory one-cycle IDLE turnaround between transactions.
- Latency: req rises in cycle 0 → strobe visible in cycle 1 → mem_ready in cycle k → x_ack in cycle k+1. Minimum 3 cycles with mem_ready in cycle 1.
- D write: d_rdata keeps its previous value; d_ack still pulses.
- x_rdata holds its value until the next read for that requester.
- stall is combinational: (i_req & ~i_ack) | (d_req & ~d_ack).
  - Deasserts in the ack cycle if no other request is pending.
  - Stays high if the other requester is waiting.
- Boundary conditions:
  - Requester drops req mid-transaction: the transaction still completes and ack still pulses.
  - mem_ready in IDLE or ACK: ignored.
  - Both requests rising in the same cycle: resolved by policy; the loser waits, stall stays 1 throughout.
  - Reset mid-GNT: strobes drop the next edge, the transaction is abandoned, no ack is issued.
  - mem_read and mem_write are never both 1.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2, ACK=2'd3);
  - owner encoding (OWN_I=1'b0, OWN_D=1'b1).
- One sub-module: arb2_pick, a combinational two-input picker.
  - Inputs: req_i, req_d, last_grant, D_PRIORITY.
  - Output: grant_d / grant_valid.

Test Plan:
- Lone I refill:
  - Stimulus: i_req=1 with i_addr=0x100; mem_ready in the 2nd GNT cycle with mem_rdata=0xDEADBEEF_...
  - Response: mem_read=1 with mem_addr=0x100 for 2 cycles; i_rdata=0xDEADBEEF_..., i_ack pulses 1 cycle, stall falls the same cycle.
- D write-back:
  - Stimulus: d_req=1, d_wen=1, d_addr=0x2A, d_wdata=0x1234.
  - Response: mem_write=1, mem_addr=0x2A, mem_wdata=0x1234, mem_read=0; d_ack pulses; d_rdata unchanged.
- Simultaneous requests with D_PRIORITY=1:
  - Response: D served first, then one IDLE cycle, then I; stall=1 continuously until i_ack.
- Simultaneous requests twice with D_PRIORITY=0, starting from reset:
  - Response: grant order D, I, D, I (alternating).
- Reset during GNT_D:
  - Stimulus: rst=1 for 1 cycle mid-wait.
  - Response: all outputs 0 next cycle, no d_ack; a subsequent request is served normally.
- Requester drops req in the first GNT cycle:
  - Response: transaction completes, ack pulses once; stray mem_ready in IDLE causes no ack.
